jt49_bus_arb: RTL and testbench



---
 rtl/jt49_bus_arb.sv | 206 ++++++++++++++++++++
 tb/tb_jt49_bus_arb.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt49_bus_arb.sv
// Two-requester arbiter and bus sequencer for the PSG BDIR/BC1/DA bus.
// Turns valid/ready register requests into timed address-latch / write / read phases.
module jt49_bus_arb #(
   parameter int unsigned PHASE_LEN  = 2,
   parameter bit          ADDR_CACHE = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic       req0_rd,
   input  logic [3:0] req0_addr,
   input  logic [7:0] req0_wdata,
   output logic [7:0] req0_rdata,
   output logic       req0_rvalid,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic       req1_rd,
   input  logic [3:0] req1_addr,
   input  logic [7:0] req1_wdata,
   output logic [7:0] req1_rdata,
   output logic       req1_rvalid,
   output logic       bdir,
   output logic       bc1,
   output logic [7:0] bus_dout,
   input  logic [7:0] bus_din,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_GAP1,
      S_DATA,
      S_GAP2
   } state_t;

   localparam logic [3:0] LAST_CNT = 4'(PHASE_LEN - 1);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       last_q, last_d;
   logic       rd_q, rd_d;
   logic [3:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic       id_q, id_d;
   logic       cache_valid_q, cache_valid_d;
   logic [3:0] cache_addr_q, cache_addr_d;
   logic       bdir_q, bdir_d;
   logic       bc1_q, bc1_d;
   logic [7:0] dout_q, dout_d;
   logic [7:0] rdata0_q, rdata0_d;
   logic [7:0] rdata1_q, rdata1_d;
   logic       rvalid0_q, rvalid0_d;
   logic       rvalid1_q, rvalid1_d;

   logic       idle;
   logic       grant1;
   logic       accept;
   logic [3:0] sel_addr;
   logic       cache_hit;
   logic       phase_done;

   // On a tie the requester that was not served last wins.
   assign idle       = (state_q == S_IDLE);
   assign grant1     = (req0_valid & req1_valid) ? ~last_q : req1_valid;
   assign req0_ready = idle & req0_valid & ~grant1;
   assign req1_ready = idle & req1_valid & grant1;
   assign accept     = req0_ready | req1_ready;
   assign sel_addr   = grant1 ? req1_addr : req0_addr;
   assign cache_hit  = ADDR_CACHE && cache_valid_q && (sel_addr == cache_addr_q);
   assign phase_done = (cnt_q == LAST_CNT);

   always_comb begin
      // NOTE: every next-state value gets a default first, so no branch can infer a latch.
      state_d       = state_q;
      cnt_d         = cnt_q;
      last_d        = last_q;
      rd_d          = rd_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      id_d          = id_q;
      cache_valid_d = cache_valid_q;
      cache_addr_d  = cache_addr_q;
      rdata0_d      = rdata0_q;
      rdata1_d      = rdata1_q;
      rvalid0_d     = 1'b0;
      rvalid1_d     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               rd_d    = grant1 ? req1_rd : req0_rd;
               addr_d  = sel_addr;
               wdata_d = grant1 ? req1_wdata : req0_wdata;
               id_d    = grant1;
               last_d  = grant1;
               cnt_d   = 4'd0;
               state_d = cache_hit ? S_DATA : S_ADDR;
            end
         end
         S_ADDR: begin
            if (phase_done) begin
               state_d       = S_GAP1;
               cnt_d         = 4'd0;
               cache_valid_d = 1'b1;
               cache_addr_d  = addr_q;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_GAP1: state_d = S_DATA;
         S_DATA: begin
            if (phase_done) begin
               state_d = S_GAP2;
               cnt_d   = 4'd0;
               // The PSG drives its data on the last read cycle; publish it during GAP2.
               if (rd_q) begin
                  if (id_q) begin
                     rdata1_d  = bus_din;
                     rvalid1_d = 1'b1;
                  end else begin
                     rdata0_d  = bus_din;
                     rvalid0_d = 1'b1;
                  end
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_GAP2:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Bus pins are decoded from the next state so they leave a register.
      bdir_d = 1'b0;
      bc1_d  = 1'b0;
      dout_d = 8'h00;
      case (state_d)
         S_ADDR: begin
            bdir_d = 1'b1;
            bc1_d  = 1'b1;
            dout_d = {4'h0, addr_d};
         end
         S_GAP1: dout_d = dout_q;
         S_DATA: begin
            if (rd_d) begin
               bc1_d = 1'b1;
            end else begin
               bdir_d = 1'b1;
               dout_d = wdata_d;
            end
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         cnt_q         <= 4'd0;
         last_q        <= 1'b1;
         rd_q          <= 1'b0;
         addr_q        <= 4'h0;
         wdata_q       <= 8'h00;
         id_q          <= 1'b0;
         cache_valid_q <= 1'b0;
         cache_addr_q  <= 4'h0;
         bdir_q        <= 1'b0;
         bc1_q         <= 1'b0;
         dout_q        <= 8'h00;
         rdata0_q      <= 8'h00;
         rdata1_q      <= 8'h00;
         rvalid0_q     <= 1'b0;
         rvalid1_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         last_q        <= last_d;
         rd_q          <= rd_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         id_q          <= id_d;
         cache_valid_q <= cache_valid_d;
         cache_addr_q  <= cache_addr_d;
         bdir_q        <= bdir_d;
         bc1_q         <= bc1_d;
         dout_q        <= dout_d;
         rdata0_q      <= rdata0_d;
         rdata1_q      <= rdata1_d;
         rvalid0_q     <= rvalid0_d;
         rvalid1_q     <= rvalid1_d;
      end
   end

   assign bdir        = bdir_q;
   assign bc1         = bc1_q;
   assign bus_dout    = dout_q;
   assign req0_rdata  = rdata0_q;
   assign req1_rdata  = rdata1_q;
   assign req0_rvalid = rvalid0_q;
   assign req1_rvalid = rvalid1_q;
   assign busy        = ~idle;

endmodule

// File: tb/tb_jt49_bus_arb.sv
// Bench for jt49_bus_arb: three configurations share one stimulus stream and are
// compared each cycle against a transaction-timeline model, plus directed literal traces.
module tb_jt49_bus_arb;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic       valid0, valid1, rd0, rd1;
   logic [3:0] addr0, addr1;
   logic [7:0] wdata0, wdata1, bus_din;

   logic [2:0] r0_rdy, r1_rdy, rv0_w, rv1_w, bdir_w, bc1_w, busy_w;
   logic [7:0] rd0_w [3];
   logic [7:0] rd1_w [3];
   logic [7:0] dout_w[3];

   // Instance 0: P=2 cache on, instance 1: P=2 cache off, instance 2: P=15 cache on.
   for (genvar g = 0; g < 3; g++) begin : g_dut
      jt49_bus_arb #(
         .PHASE_LEN  ((g == 2) ? 15 : 2),
         .ADDR_CACHE (g != 1)
      ) u_dut (
         .clk         (clk),
         .rst_n       (rst_n),
         .req0_valid  (valid0),
         .req0_ready  (r0_rdy[g]),
         .req0_rd     (rd0),
         .req0_addr   (addr0),
         .req0_wdata  (wdata0),
         .req0_rdata  (rd0_w[g]),
         .req0_rvalid (rv0_w[g]),
         .req1_valid  (valid1),
         .req1_ready  (r1_rdy[g]),
         .req1_rd     (rd1),
         .req1_addr   (addr1),
         .req1_wdata  (wdata1),
         .req1_rdata  (rd1_w[g]),
         .req1_rvalid (rv1_w[g]),
         .bdir        (bdir_w[g]),
         .bc1         (bc1_w[g]),
         .bus_dout    (dout_w[g]),
         .bus_din     (bus_din),
         .busy        (busy_w[g])
      );
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // ---------------- behavioural model: one transaction timeline per instance
   int         P_OF [3] = '{2, 2, 15};
   bit         C_OF [3] = '{1'b1, 1'b0, 1'b1};
   bit         m_act [3];
   int         m_k [3];     // offset of the current cycle from the accept cycle
   int         m_off [3];   // 0 for a cached transaction, else P+1 (ADDR+GAP1)
   bit         m_rd [3];
   logic [3:0] m_addr [3];
   logic [7:0] m_wd [3];
   int         m_id [3];
   int         m_last [3];
   bit         m_cv [3];
   logic [3:0] m_ca [3];
   logic [7:0] m_rdata [3][2];

   task automatic model_reset(input int i);
      m_act[i] = 0; m_k[i] = 0; m_last[i] = 1; m_cv[i] = 0;
      m_rdata[i][0] = 8'h00; m_rdata[i][1] = 8'h00;
   endtask

   function automatic int grant_of(input int i);
      if (valid0 && valid1) return (m_last[i] == 0) ? 1 : 0;
      return valid0 ? 0 : 1;
   endfunction

   function automatic logic [30:0] exp_vec(input int i);
      logic [1:0] b = 2'b00, rdy = 2'b00, rv = 2'b00;
      logic       y = 1'b0;
      logic [7:0] d = 8'h00;
      int k = m_k[i], o = m_off[i], p = P_OF[i], g;
      if (m_act[i]) begin
         y = 1'b1;
         if (o != 0 && k <= p) begin
            b = 2'b11; d = {4'h0, m_addr[i]};
         end else if (o != 0 && k == p + 1) begin
            d = {4'h0, m_addr[i]};
         end else if (k <= o + p) begin
            b = m_rd[i] ? 2'b01 : 2'b10;
            d = m_rd[i] ? 8'h00 : m_wd[i];
         end else if (m_rd[i]) begin
            rv = (m_id[i] == 0) ? 2'b10 : 2'b01;
         end
      end else begin
         g = grant_of(i);
         rdy = {valid0 && g == 0, valid1 && g == 1};
      end
      return {b, y, d, rdy, rv, m_rdata[i][0], m_rdata[i][1]};
   endfunction

   function automatic logic [30:0] act_vec(input int i);
      return {bdir_w[i], bc1_w[i], busy_w[i], dout_w[i], r0_rdy[i], r1_rdy[i],
              rv0_w[i], rv1_w[i], rd0_w[i], rd1_w[i]};
   endfunction

   task automatic model_step(input int i);
      int g, p = P_OF[i];
      if (m_act[i]) begin
         if (m_k[i] == m_off[i] + p && m_rd[i]) m_rdata[i][m_id[i]] = bus_din;
         if (m_off[i] != 0 && m_k[i] == p) begin
            m_cv[i] = 1; m_ca[i] = m_addr[i];
         end
         m_k[i]++;
         if (m_k[i] == m_off[i] + p + 2) m_act[i] = 0;
      end else if (valid0 || valid1) begin
         g = grant_of(i);
         m_act[i]  = 1;
         m_k[i]    = 1;
         m_id[i]   = g;
         m_last[i] = g;
         m_rd[i]   = (g == 1) ? rd1 : rd0;
         m_addr[i] = (g == 1) ? addr1 : addr0;
         m_wd[i]   = (g == 1) ? wdata1 : wdata0;
         m_off[i]  = (C_OF[i] && m_cv[i] && m_addr[i] == m_ca[i]) ? 0 : p + 1;
      end
   endtask

   int cyc = 0;
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         for (int i = 0; i < 3; i++) begin
            if (!rst_n) model_reset(i);
            check($sformatf("model_i%0d_c%0d", i, cyc), 32'(act_vec(i)), 32'(exp_vec(i)));
            if (rst_n) model_step(i);
         end
      end
   end

   // ---------------- directed literal traces
   logic [28:0] tr0 [7];
   logic [28:0] tr1 [7];

   function automatic logic [28:0] pk(input logic [1:0] b, input logic y, input logic [7:0] d,
                                      input logic [1:0] rv, input logic [7:0] r1);
      return {b, y, d, rv, 8'h00, r1};
   endfunction

   function automatic logic [28:0] tvec(input int i);
      return {bdir_w[i], bc1_w[i], busy_w[i], dout_w[i], rv0_w[i], rv1_w[i], rd0_w[i], rd1_w[i]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic trace(input string nm, input bit both);
      for (int k = 0; k < 7; k++) begin
         tick();
         if (k == 0) begin
            valid0 = 1'b0;
            valid1 = 1'b0;
         end
         @(negedge clk);
         check($sformatf("%s_i0_k%0d", nm, k + 1), 32'(tvec(0)), 32'(tr0[k]));
         if (both) check($sformatf("%s_i1_k%0d", nm, k + 1), 32'(tvec(1)), 32'(tr1[k]));
      end
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      @(negedge clk);
      while (busy_w != 3'b000 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check(nm, 32'(busy_w), 32'd0);
   endtask

   logic [3:0] atab [4] = '{4'd3, 4'd7, 4'd14, 4'd2};

   initial begin
      int n, na, nd, nb;
      rst_n = 1'b0; valid0 = 0; valid1 = 0; rd0 = 0; rd1 = 0;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; bus_din = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ctrl", 32'({bdir_w, bc1_w, busy_w, rv0_w, rv1_w}), 32'd0);
      check("reset_data", 32'({dout_w[0], rd0_w[0], rd1_w[0]}), 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      // req0 write addr 7 / 0x38, empty cache: full sequence everywhere
      tick();
      valid0 = 1; rd0 = 0; addr0 = 4'd7; wdata0 = 8'h38;
      @(negedge clk);
      check("wr1_ready", 32'({r0_rdy, r1_rdy}), 32'b111_000);
      tr0 = '{pk(2'b11,1,8'h07,0,0), pk(2'b11,1,8'h07,0,0), pk(2'b00,1,8'h07,0,0),
              pk(2'b10,1,8'h38,0,0), pk(2'b10,1,8'h38,0,0), pk(2'b00,1,8'h00,0,0),
              pk(2'b00,0,8'h00,0,0)};
      trace("wr1", 1'b0);
      wait_idle("wr1_idle");

      // same address again: cached on instance 0, full on instance 1
      tick();
      valid0 = 1; addr0 = 4'd7; wdata0 = 8'h3F;
      tr0 = '{pk(2'b10,1,8'h3F,0,0), pk(2'b10,1,8'h3F,0,0), pk(2'b00,1,8'h00,0,0),
              pk(2'b00,0,8'h00,0,0), pk(2'b00,0,8'h00,0,0), pk(2'b00,0,8'h00,0,0),
              pk(2'b00,0,8'h00,0,0)};
      tr1 = '{pk(2'b11,1,8'h07,0,0), pk(2'b11,1,8'h07,0,0), pk(2'b00,1,8'h07,0,0),
              pk(2'b10,1,8'h3F,0,0), pk(2'b10,1,8'h3F,0,0), pk(2'b00,1,8'h00,0,0),
              pk(2'b00,0,8'h00,0,0)};
      trace("wr2", 1'b1);
      wait_idle("wr2_idle");

      // req1 read addr 14 with bus_din 0xA5
      tick();
      valid1 = 1; rd1 = 1; addr1 = 4'd14; bus_din = 8'hA5;
      @(negedge clk);
      check("rd_ready", 32'({r0_rdy, r1_rdy}), 32'b000_111);
      tr0 = '{pk(2'b11,1,8'h0E,0,0), pk(2'b11,1,8'h0E,0,0), pk(2'b00,1,8'h0E,0,0),
              pk(2'b01,1,8'h00,0,0), pk(2'b01,1,8'h00,0,0), pk(2'b00,1,8'h00,2'b01,8'hA5),
              pk(2'b00,0,8'h00,0,8'hA5)};
      trace("rd", 1'b0);
      wait_idle("rd_idle");

      // both requesters valid continuously: alternating grants every 7 cycles
      tick();
      valid0 = 1; valid1 = 1; rd0 = 0; rd1 = 0;
      addr0 = 4'd3; addr1 = 4'd9; wdata0 = 8'h44; wdata1 = 8'h99;
      for (int c = 0; c < 28; c++) begin
         if (c != 0) tick();
         @(negedge clk);
         check($sformatf("alt_c%0d", c), 32'({r0_rdy[0], r1_rdy[0]}),
               32'({c % 14 == 0, c % 14 == 7}));
      end
      tick();
      valid0 = 0; valid1 = 0;
      wait_idle("alt_idle");

      // asynchronous reset during a DATA write phase
      tick();
      valid0 = 1; addr0 = 4'd5; wdata0 = 8'h55;
      tick();
      valid0 = 0;
      n = 0;
      @(negedge clk);
      while (!(bdir_w[0] && !bc1_w[0]) && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("reach_data", 32'({bdir_w[0], bc1_w[0]}), 32'b10);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check("async_rst", 32'({bdir_w, bc1_w, busy_w}), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      valid0 = 1; addr0 = 4'd5; wdata0 = 8'h5A;
      @(negedge clk);
      check("post_rst_ready", 32'(r0_rdy[0]), 32'd1);
      tr0 = '{pk(2'b11,1,8'h05,0,0), pk(2'b11,1,8'h05,0,0), pk(2'b00,1,8'h05,0,0),
              pk(2'b10,1,8'h5A,0,0), pk(2'b10,1,8'h5A,0,0), pk(2'b00,1,8'h00,0,0),
              pk(2'b00,0,8'h00,0,0)};
      trace("post_rst", 1'b0);
      wait_idle("post_rst_idle");

      // PHASE_LEN=15: phase lengths and total busy time
      tick();
      valid0 = 1; addr0 = 4'd11; wdata0 = 8'h11;
      @(negedge clk);
      check("p15_ready", 32'(r0_rdy[2]), 32'd1);
      na = 0; nd = 0; nb = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         valid0 = 0;
         @(negedge clk);
         if (bdir_w[2] && bc1_w[2]) na++;
         if (bdir_w[2] && !bc1_w[2]) nd++;
         if (busy_w[2]) nb++;
      end
      check("p15_addr_cycles", 32'(na), 32'd15);
      check("p15_data_cycles", 32'(nd), 32'd15);
      check("p15_busy_cycles", 32'(nb), 32'd32);

      // randomized traffic over a small address set so the cache gets hits
      for (int c = 0; c < 4000; c++) begin
         tick();
         rst_n   = ($urandom_range(0, 299) != 0);
         valid0  = ($urandom_range(0, 2) != 0);
         valid1  = ($urandom_range(0, 2) != 0);
         rd0     = $urandom_range(0, 1) != 0;
         rd1     = $urandom_range(0, 1) != 0;
         addr0   = atab[$urandom_range(0, 3)];
         addr1   = atab[$urandom_range(0, 3)];
         wdata0  = 8'($urandom);
         wdata1  = 8'($urandom);
         bus_din = 8'($urandom);
      end
      tick();
      rst_n = 1'b1; valid0 = 0; valid1 = 0;
      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
